intrp_responder: RTL and testbench

INTRP_RESPONDER -- requirements
Module: intrp_responder

---
 rtl/intrp_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_intrp_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intrp_responder.sv
// Interrupt-request responder: accepts AFU interrupt commands, delivers them to
// the host interrupt queue and answers with intrp_resp / intrp_rdy responses.
module intrp_responder #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [7:0]      cfg_rsp_delay,
  input  logic            cfg_force_retry,
  input  logic [15:0]     cfg_rdy_timeout,
  input  logic            afu_cmd_valid,
  input  logic [7:0]      afu_cmd_opcode,
  input  logic [67:0]     afu_cmd_obj,
  input  logic [15:0]     afu_cmd_afutag,
  input  logic [19:0]     afu_cmd_pasid,
  input  logic [11:0]     afu_cmd_actag,
  output logic            afu_rsp_valid,
  output logic [7:0]      afu_rsp_opcode,
  output logic [15:0]     afu_rsp_afutag,
  output logic [3:0]      afu_rsp_code,
  input  logic            host_busy,
  output logic            host_int_valid,
  input  logic            host_int_ack,
  output logic [63:0]     host_int_src,
  output logic [19:0]     host_int_pasid,
  output logic [11:0]     host_int_actag,
  output logic [CNTW-1:0] cnt_done,
  output logic [CNTW-1:0] cnt_retry,
  output logic [CNTW-1:0] cnt_pending,
  output logic [CNTW-1:0] cnt_fail,
  output logic            proto_err
);

  typedef enum logic [6:0] {
    IDLE     = 7'b000_0001,
    DELAY    = 7'b000_0010,
    EVAL     = 7'b000_0100,
    HOST     = 7'b000_1000,
    RSP      = 7'b001_0000,
    WAIT_RDY = 7'b010_0000,
    RDY      = 7'b100_0000
  } state_t;

  localparam logic [3:0] CODE_DONE  = 4'h0;
  localparam logic [3:0] CODE_RETRY = 4'h2;
  localparam logic [3:0] CODE_PEND  = 4'h4;
  localparam logic [3:0] CODE_FAIL  = 4'hE;
  localparam logic [7:0] OP_INTRP   = 8'h58;
  localparam logic [7:0] OP_RESP    = 8'h0C;
  localparam logic [7:0] OP_RDY     = 8'h1A;

  state_t        state_r;
  logic [7:0]    opc_r;
  logic [67:0]   obj_r;
  logic [15:0]   tag_r;
  logic [19:0]   pasid_r;
  logic [11:0]   actag_r;
  logic [3:0]    code_r;
  logic [7:0]    dly_cnt_r;
  logic [15:0]   rdy_cnt_r;
  logic          opc_ok_s;
  logic          rdy_hit_s;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic en);
    if (en && !(&v)) begin
      return v + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // 0x58..0x5B share the upper six opcode bits
  assign opc_ok_s  = (afu_cmd_opcode[7:2] == 6'b010110);
  // >= keeps a lowered timeout from being skipped past
  assign rdy_hit_s = (cfg_rdy_timeout != 16'd0) &&
                     (({1'b0, rdy_cnt_r} + 17'd1) >= {1'b0, cfg_rdy_timeout});

  // Transaction FSM with all response and host-side outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= IDLE;
      opc_r          <= 8'd0;
      obj_r          <= 68'd0;
      tag_r          <= 16'd0;
      pasid_r        <= 20'd0;
      actag_r        <= 12'd0;
      code_r         <= 4'd0;
      dly_cnt_r      <= 8'd0;
      rdy_cnt_r      <= 16'd0;
      afu_rsp_valid  <= 1'b0;
      afu_rsp_opcode <= 8'd0;
      afu_rsp_afutag <= 16'd0;
      afu_rsp_code   <= 4'd0;
      host_int_valid <= 1'b0;
      host_int_src   <= 64'd0;
      host_int_pasid <= 20'd0;
      host_int_actag <= 12'd0;
      proto_err      <= 1'b0;
    end else begin
      afu_rsp_valid  <= 1'b0;
      afu_rsp_opcode <= 8'd0;
      afu_rsp_afutag <= 16'd0;
      afu_rsp_code   <= 4'd0;
      if (afu_cmd_valid && ((state_r != IDLE) || !opc_ok_s)) begin
        proto_err <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (afu_cmd_valid && opc_ok_s) begin
            opc_r   <= afu_cmd_opcode;
            obj_r   <= afu_cmd_obj;
            tag_r   <= afu_cmd_afutag;
            pasid_r <= afu_cmd_pasid;
            actag_r <= afu_cmd_actag;
            if (cfg_rsp_delay != 8'd0) begin
              dly_cnt_r <= cfg_rsp_delay;
              state_r   <= DELAY;
            end else begin
              state_r <= EVAL;
            end
          end
        end
        DELAY: begin
          if (dly_cnt_r == 8'd1) begin
            state_r <= EVAL;
          end else begin
            dly_cnt_r <= dly_cnt_r - 8'd1;
          end
        end
        EVAL: begin
          if ((opc_r != OP_INTRP) || (obj_r[67:64] != 4'h0)) begin
            code_r         <= CODE_FAIL;
            afu_rsp_valid  <= 1'b1;
            afu_rsp_opcode <= OP_RESP;
            afu_rsp_afutag <= tag_r;
            afu_rsp_code   <= CODE_FAIL;
            state_r        <= RSP;
          end else if (cfg_force_retry) begin
            code_r         <= CODE_RETRY;
            afu_rsp_valid  <= 1'b1;
            afu_rsp_opcode <= OP_RESP;
            afu_rsp_afutag <= tag_r;
            afu_rsp_code   <= CODE_RETRY;
            state_r        <= RSP;
          end else if (host_busy) begin
            code_r         <= CODE_PEND;
            afu_rsp_valid  <= 1'b1;
            afu_rsp_opcode <= OP_RESP;
            afu_rsp_afutag <= tag_r;
            afu_rsp_code   <= CODE_PEND;
            state_r        <= RSP;
          end else begin
            host_int_valid <= 1'b1;
            host_int_src   <= obj_r[63:0];
            host_int_pasid <= pasid_r;
            host_int_actag <= actag_r;
            state_r        <= HOST;
          end
        end
        HOST: begin
          if (host_int_ack) begin
            host_int_valid <= 1'b0;
            host_int_src   <= 64'd0;
            host_int_pasid <= 20'd0;
            host_int_actag <= 12'd0;
            code_r         <= CODE_DONE;
            afu_rsp_valid  <= 1'b1;
            afu_rsp_opcode <= OP_RESP;
            afu_rsp_afutag <= tag_r;
            afu_rsp_code   <= CODE_DONE;
            state_r        <= RSP;
          end
        end
        RSP: begin
          if (code_r == CODE_PEND) begin
            rdy_cnt_r <= 16'd0;
            state_r   <= WAIT_RDY;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_RDY: begin
          if (!host_busy) begin
            afu_rsp_valid  <= 1'b1;
            afu_rsp_opcode <= OP_RDY;
            afu_rsp_afutag <= tag_r;
            afu_rsp_code   <= CODE_DONE;
            state_r        <= RDY;
          end else if (rdy_hit_s) begin
            afu_rsp_valid  <= 1'b1;
            afu_rsp_opcode <= OP_RDY;
            afu_rsp_afutag <= tag_r;
            afu_rsp_code   <= CODE_RETRY;
            state_r        <= RDY;
          end else begin
            rdy_cnt_r <= rdy_cnt_r + 16'd1;
          end
        end
        RDY: begin
          state_r <= IDLE;
        end
        default: begin
          host_int_valid <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

  // Saturating event counters, bumped once in each RSP cycle by its code.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_done    <= {CNTW{1'b0}};
      cnt_retry   <= {CNTW{1'b0}};
      cnt_pending <= {CNTW{1'b0}};
      cnt_fail    <= {CNTW{1'b0}};
    end else if (state_r == RSP) begin
      cnt_done    <= sat_inc(cnt_done,    code_r == CODE_DONE);
      cnt_retry   <= sat_inc(cnt_retry,   code_r == CODE_RETRY);
      cnt_pending <= sat_inc(cnt_pending, code_r == CODE_PEND);
      cnt_fail    <= sat_inc(cnt_fail,    code_r == CODE_FAIL);
    end
  end

endmodule

// File: tb/tb_intrp_responder.sv
// Scoreboard bench for intrp_responder: directed commands push expected
// responses, independent monitors pop and compare what the DUT presents.
module tb_intrp_responder;

  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [7:0]      cfg_rsp_delay = 8'd0;
  logic            cfg_force_retry = 1'b0;
  logic [15:0]     cfg_rdy_timeout = 16'd0;
  logic            afu_cmd_valid = 1'b0;
  logic [7:0]      afu_cmd_opcode = 8'd0;
  logic [67:0]     afu_cmd_obj = 68'd0;
  logic [15:0]     afu_cmd_afutag = 16'd0;
  logic [19:0]     afu_cmd_pasid = 20'd0;
  logic [11:0]     afu_cmd_actag = 12'd0;
  logic            afu_rsp_valid;
  logic [7:0]      afu_rsp_opcode;
  logic [15:0]     afu_rsp_afutag;
  logic [3:0]      afu_rsp_code;
  logic            host_busy = 1'b0;
  logic            host_int_valid;
  logic            host_int_ack = 1'b0;
  logic [63:0]     host_int_src;
  logic [19:0]     host_int_pasid;
  logic [11:0]     host_int_actag;
  logic [CNTW-1:0] cnt_done, cnt_retry, cnt_pending, cnt_fail;
  logic            proto_err;

  intrp_responder #(.CNTW(CNTW)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_rsp_delay(cfg_rsp_delay), .cfg_force_retry(cfg_force_retry),
    .cfg_rdy_timeout(cfg_rdy_timeout),
    .afu_cmd_valid(afu_cmd_valid), .afu_cmd_opcode(afu_cmd_opcode),
    .afu_cmd_obj(afu_cmd_obj), .afu_cmd_afutag(afu_cmd_afutag),
    .afu_cmd_pasid(afu_cmd_pasid), .afu_cmd_actag(afu_cmd_actag),
    .afu_rsp_valid(afu_rsp_valid), .afu_rsp_opcode(afu_rsp_opcode),
    .afu_rsp_afutag(afu_rsp_afutag), .afu_rsp_code(afu_rsp_code),
    .host_busy(host_busy), .host_int_valid(host_int_valid),
    .host_int_ack(host_int_ack), .host_int_src(host_int_src),
    .host_int_pasid(host_int_pasid), .host_int_actag(host_int_actag),
    .cnt_done(cnt_done), .cnt_retry(cnt_retry), .cnt_pending(cnt_pending),
    .cnt_fail(cnt_fail), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] op; logic [15:0] tag; logic [3:0] code; int at; } rsp_t;
  typedef struct { logic [63:0] src; logic [19:0] pasid; logic [11:0] actag; } hst_t;

  rsp_t rsp_q[$];
  hst_t hst_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   ack_en = 1'b1;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic exp_rsp(input logic [7:0] op, input logic [15:0] tag, input logic [3:0] code, input int at);
    rsp_t e;
    e.op = op; e.tag = tag; e.code = code; e.at = at;
    rsp_q.push_back(e);
  endtask

  task automatic exp_host(input logic [63:0] src, input logic [19:0] pasid, input logic [11:0] actag);
    hst_t h;
    h.src = src; h.pasid = pasid; h.actag = actag;
    hst_q.push_back(h);
  endtask

  // Presents one command for one cycle; at returns the command cycle number.
  task automatic send_cmd(input bit now, input logic [7:0] op, input logic [67:0] obj,
                          input logic [15:0] tag, input logic [19:0] pasid,
                          input logic [11:0] actag, output int at);
    if (!now) begin
      @(posedge clk); #1;
    end
    afu_cmd_valid  = 1'b1;
    afu_cmd_opcode = op;
    afu_cmd_obj    = obj;
    afu_cmd_afutag = tag;
    afu_cmd_pasid  = pasid;
    afu_cmd_actag  = actag;
    at = cyc;
    @(posedge clk); #1;
    afu_cmd_valid  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((rsp_q.size() != 0 || hst_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk(name, 68'(rsp_q.size() + hst_q.size()), 68'd0);
    rsp_q.delete();
    hst_q.delete();
    wait_cycles(2);
  endtask

  // Response monitor: every cycle with afu_rsp_valid consumes one expectation.
  rsp_t me;
  always @(negedge clk) begin
    if (afu_rsp_valid) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 68'(afu_rsp_valid), 68'd0);
      end else begin
        me = rsp_q.pop_front();
        chk("rsp_opcode", 68'(afu_rsp_opcode), 68'(me.op));
        chk("rsp_afutag", 68'(afu_rsp_afutag), 68'(me.tag));
        chk("rsp_code",   68'(afu_rsp_code),   68'(me.code));
        if (me.at >= 0) chk("rsp_cycle", 68'(cyc), 68'(me.at));
      end
    end
  end

  // Host monitor: each rising host_int_valid must match a queued delivery.
  logic hv_d = 1'b0;
  hst_t mh;
  always @(negedge clk) begin
    if (host_int_valid && !hv_d) begin
      if (hst_q.size() == 0) begin
        chk("host_unexpected", 68'(host_int_valid), 68'd0);
      end else begin
        mh = hst_q.pop_front();
        chk("host_src",   68'(host_int_src),   68'(mh.src));
        chk("host_pasid", 68'(host_int_pasid), 68'(mh.pasid));
        chk("host_actag", 68'(host_int_actag), 68'(mh.actag));
      end
    end
    hv_d = host_int_valid;
  end

  // Host model: acknowledges one cycle after it sees host_int_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (host_int_valid && ack_en) begin
        @(posedge clk); #1 host_int_ack = 1'b1;
        @(posedge clk); #1 host_int_ack = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int at;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid",  68'(afu_rsp_valid),  68'd0);
    chk("rst_host_valid", 68'(host_int_valid), 68'd0);
    chk("rst_proto_err",  68'(proto_err),      68'd0);
    chk("rst_cnt_done",   68'(cnt_done),       68'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // Delayed host delivery
    cfg_rsp_delay = 8'd3;
    send_cmd(1'b0, 8'h58, 68'h0_DEAD, 16'hC000, 20'h12345, 12'hABC, at);
    exp_host(64'hDEAD, 20'h12345, 12'hABC);
    exp_rsp(8'h0C, 16'hC000, 4'h0, at + 7);
    drain("drain_done");
    chk("cnt_done_1", 68'(cnt_done), 68'd1);

    // Forced retry, no host delivery
    cfg_rsp_delay = 8'd0;
    cfg_force_retry = 1'b1;
    send_cmd(1'b0, 8'h58, 68'h1234, 16'h0001, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h0001, 4'h2, at + 2);
    drain("drain_retry");
    chk("cnt_retry_1", 68'(cnt_retry), 68'd1);

    // Failure beats forced retry; retry beats busy
    send_cmd(1'b0, 8'h5A, 68'h1, 16'h005A, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h005A, 4'hE, at + 2);
    drain("drain_fail_prio");
    host_busy = 1'b1;
    send_cmd(1'b0, 8'h58, 68'h2, 16'h0BB0, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h0BB0, 4'h2, at + 2);
    drain("drain_retry_prio");
    host_busy = 1'b0;
    cfg_force_retry = 1'b0;

    // Failed: wrong opcode, then object high bits set with delay 2
    send_cmd(1'b0, 8'h59, 68'h55, 16'h0059, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h0059, 4'hE, at + 2);
    drain("drain_fail_op");
    cfg_rsp_delay = 8'd2;
    send_cmd(1'b0, 8'h58, 68'h1_0000_0000_0000_0077, 16'h0F0F, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h0F0F, 4'hE, at + 4);
    drain("drain_fail_obj");
    cfg_rsp_delay = 8'd0;
    chk("cnt_fail_3",  68'(cnt_fail),  68'd3);
    chk("cnt_retry_2", 68'(cnt_retry), 68'd2);

    // Pending, host released 10 cycles later
    host_busy = 1'b1;
    send_cmd(1'b0, 8'h58, 68'hBEEF, 16'h0A0A, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h0A0A, 4'h4, at + 2);
    exp_rsp(8'h1A, 16'h0A0A, 4'h0, at + 12);
    wait_cycles(10);
    host_busy = 1'b0;
    drain("drain_pending");
    chk("cnt_pending_1", 68'(cnt_pending), 68'd1);
    chk("cnt_done_still", 68'(cnt_done), 68'd1);

    // Ready timeout of 5 with host held busy
    cfg_rdy_timeout = 16'd5;
    host_busy = 1'b1;
    send_cmd(1'b0, 8'h58, 68'h42, 16'h5555, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h5555, 4'h4, at + 2);
    exp_rsp(8'h1A, 16'h5555, 4'h2, at + 8);
    drain("drain_timeout");

    // Timeout and release in the same cycle: release wins
    cfg_rdy_timeout = 16'd3;
    send_cmd(1'b0, 8'h58, 68'h43, 16'h6666, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h6666, 4'h4, at + 2);
    exp_rsp(8'h1A, 16'h6666, 4'h0, at + 6);
    wait_cycles(4);
    host_busy = 1'b0;
    drain("drain_tie");
    cfg_rdy_timeout = 16'd0;
    chk("cnt_pending_3", 68'(cnt_pending), 68'd3);
    chk("cnt_retry_kept", 68'(cnt_retry), 68'd2);
    chk("proto_err_clean", 68'(proto_err), 68'd0);

    // Second command while held in HOST is dropped
    ack_en = 1'b0;
    send_cmd(1'b0, 8'h58, 68'hCAFE_F00D, 16'h7777, 20'hFEDCB, 12'h321, at);
    exp_host(64'hCAFE_F00D, 20'hFEDCB, 12'h321);
    exp_rsp(8'h0C, 16'h7777, 4'h0, -1);
    n = 0;
    while (!host_int_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("host_valid_seen", 68'(host_int_valid), 68'd1);
    send_cmd(1'b0, 8'h58, 68'h99, 16'h8888, 20'h0, 12'h0, at);
    @(negedge clk);
    chk("proto_err_drop", 68'(proto_err), 68'd1);
    ack_en = 1'b1;
    drain("drain_host_hold");
    chk("cnt_done_2", 68'(cnt_done), 68'd2);

    // Reset while waiting for ready
    host_busy = 1'b1;
    send_cmd(1'b0, 8'h58, 68'h1, 16'h9999, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h9999, 4'h4, at + 2);
    wait_cycles(5);
    chk("pend_before_rst", 68'(rsp_q.size()), 68'd0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_rsp_valid", 68'(afu_rsp_valid), 68'd0);
    chk("arst_cnt_pend",  68'(cnt_pending),   68'd0);
    chk("arst_cnt_done",  68'(cnt_done),      68'd0);
    chk("arst_proto_err", 68'(proto_err),     68'd0);
    chk("arst_host",      68'(host_int_valid), 68'd0);
    host_busy = 1'b0;
    wait_cycles(3);
    @(posedge clk); #1 resetn = 1'b1;
    cfg_force_retry = 1'b1;
    send_cmd(1'b1, 8'h58, 68'h3, 16'h0B0B, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h0B0B, 4'h2, at + 2);
    drain("drain_post_rst");
    cfg_force_retry = 1'b0;
    chk("cnt_retry_post", 68'(cnt_retry), 68'd1);

    // Unknown opcode in IDLE: ignored, flagged, next command still served
    send_cmd(1'b0, 8'h20, 68'h0, 16'h2020, 20'h0, 12'h0, at);
    wait_cycles(3);
    chk("proto_err_badop", 68'(proto_err), 68'd1);
    send_cmd(1'b0, 8'h5B, 68'h0, 16'h5B5B, 20'h0, 12'h0, at);
    exp_rsp(8'h0C, 16'h5B5B, 4'hE, at + 2);
    drain("drain_final");
    chk("cnt_fail_post", 68'(cnt_fail), 68'd1);

    wait_cycles(10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
